team_select: RTL and testbench

TEAM_SELECT -- requirements
Module: team_select

---
 rtl/team_select.sv | 141 ++++++++++++++
 tb/tb_team_select.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/team_select.sv
// Team selection front end: picks three of six roster ids on a 2x3 grid with the keyboard,
// hands the keyboard to the battle stage, and counts won battles.
module team_select #(
  parameter int unsigned NUM_MONS = 6
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            start,
  input  logic [7:0]      keycode,
  input  logic            end_battle,
  input  logic            result,
  output logic [2:0][2:0] team,
  output logic            is_battle,
  output logic [2:0]      cursor,
  output logic [5:0]      picked_mask,
  output logic [1:0]      picked_count,
  output logic [3:0]      wins
);

  localparam logic [7:0] KeyW     = 8'h1A;
  localparam logic [7:0] KeyA     = 8'h04;
  localparam logic [7:0] KeyS     = 8'h16;
  localparam logic [7:0] KeyD     = 8'h07;
  localparam logic [7:0] KeyEnter = 8'h28;
  localparam logic [7:0] KeyBksp  = 8'h2A;

  typedef enum logic [1:0] {
    StIdle,
    StSelect,
    StConfirm,
    StBattle
  } state_e;

  state_e           r_state;
  logic [7:0]       r_prev_key;
  logic [2:0][2:0]  r_team;
  logic [2:0]       r_cursor;
  logic [5:0]       r_mask;
  logic [1:0]       r_count;
  logic [3:0]       r_wins;

  logic             w_key_evt;
  logic             w_bottom_row;
  logic [1:0]       w_col;
  logic             w_has_row_below;
  logic             w_cur_picked;
  logic [1:0]       w_last;
  logic [2:0]       w_last_id;

  // A new nonzero code is one event; holding the key produces no further events.
  assign w_key_evt       = (keycode != 8'h00) && (keycode != r_prev_key);
  assign w_bottom_row    = (r_cursor >= 3'd3);
  assign w_col           = w_bottom_row ? 2'(r_cursor - 3'd3) : 2'(r_cursor);
  assign w_has_row_below = (32'(r_cursor) + 32'd3) < NUM_MONS;
  assign w_cur_picked    = r_mask[r_cursor];
  assign w_last          = r_count - 2'd1;
  assign w_last_id       = r_team[w_last];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= StIdle;
      r_prev_key <= 8'h00;
      r_team     <= '0;
      r_cursor   <= 3'd0;
      r_mask     <= 6'd0;
      r_count    <= 2'd0;
      r_wins     <= 4'd0;
    end else begin
      r_prev_key <= keycode;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_state  <= StSelect;
            r_team   <= '0;
            r_mask   <= 6'd0;
            r_count  <= 2'd0;
            r_cursor <= 3'd0;
          end
        end

        StSelect: begin
          if (w_key_evt) begin
            case (keycode)
              KeyW: if (w_bottom_row) r_cursor <= r_cursor - 3'd3;
              KeyS: if (w_has_row_below) r_cursor <= r_cursor + 3'd3;
              KeyA: if (w_col != 2'd0) r_cursor <= r_cursor - 3'd1;
              KeyD: if (w_col != 2'd2) r_cursor <= r_cursor + 3'd1;
              KeyEnter: begin
                if (!w_cur_picked) begin
                  r_team[r_count]  <= r_cursor;
                  r_mask[r_cursor] <= 1'b1;
                  r_count          <= r_count + 2'd1;
                  if (r_count == 2'd2) r_state <= StConfirm;
                end
              end
              KeyBksp: begin
                if (r_count != 2'd0) begin
                  r_team[w_last]    <= 3'd0;
                  r_mask[w_last_id] <= 1'b0;
                  r_count           <= w_last;
                end
              end
              default: ;
            endcase
          end
        end

        StConfirm: begin
          if (w_key_evt) begin
            if (keycode == KeyEnter) begin
              r_state <= StBattle;
            end else if (keycode == KeyBksp) begin
              // Count is 3 here, so w_last addresses slot 2.
              r_team[w_last]    <= 3'd0;
              r_mask[w_last_id] <= 1'b0;
              r_count           <= w_last;
              r_state           <= StSelect;
            end
          end
        end

        StBattle: begin
          if (end_battle) begin
            r_state <= StIdle;
            if (result && (r_wins != 4'd15)) r_wins <= r_wins + 4'd1;
          end
        end

        default: r_state <= StIdle;
      endcase
    end
  end

  assign team         = r_team;
  assign is_battle    = (r_state == StBattle);
  assign cursor       = r_cursor;
  assign picked_mask  = r_mask;
  assign picked_count = r_count;
  assign wins         = r_wins;

endmodule

// File: tb/tb_team_select.sv
// Scoreboard bench for team_select: a behavioural model queues the expected outputs for each
// driven cycle and they are compared one clock later.
module tb_team_select;

  localparam logic [7:0] KW = 8'h1A;
  localparam logic [7:0] KA = 8'h04;
  localparam logic [7:0] KS = 8'h16;
  localparam logic [7:0] KD = 8'h07;
  localparam logic [7:0] KE = 8'h28;
  localparam logic [7:0] KB = 8'h2A;

  logic            Clk;
  logic            Reset;
  logic            start;
  logic [7:0]      keycode;
  logic            end_battle;
  logic            result;
  logic [2:0][2:0] team;
  logic            is_battle;
  logic [2:0]      cursor;
  logic [5:0]      picked_mask;
  logic [1:0]      picked_count;
  logic [3:0]      wins;

  team_select dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .start       (start),
    .keycode     (keycode),
    .end_battle  (end_battle),
    .result      (result),
    .team        (team),
    .is_battle   (is_battle),
    .cursor      (cursor),
    .picked_mask (picked_mask),
    .picked_count(picked_count),
    .wins        (wins)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [8:0] team;
    logic [2:0] cursor;
    logic [5:0] mask;
    logic [1:0] count;
    logic [3:0] wins;
    logic       isb;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model state: 0 idle, 1 select, 2 confirm, 3 battle.
  int       m_state;
  int       m_team[3];
  int       m_cursor;
  int       m_mask;
  int       m_count;
  int       m_wins;
  bit [7:0] m_prev;

  task automatic check_eq(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_team   = '{0, 0, 0};
    m_cursor = 0;
    m_mask   = 0;
    m_count  = 0;
    m_wins   = 0;
    m_prev   = 8'h00;
  endtask

  task automatic model_step(input bit [7:0] k, input bit st, input bit eb, input bit res);
    bit evt;
    evt    = (k != 8'h00) && (k != m_prev);
    m_prev = k;
    case (m_state)
      0: if (st) begin
        m_state = 1; m_team = '{0, 0, 0}; m_mask = 0; m_count = 0; m_cursor = 0;
      end
      1: if (evt) begin
        if (k == KW && m_cursor >= 3) m_cursor -= 3;
        else if (k == KS && m_cursor < 3) m_cursor += 3;
        else if (k == KA && (m_cursor % 3) != 0) m_cursor -= 1;
        else if (k == KD && (m_cursor % 3) != 2) m_cursor += 1;
        else if (k == KE && ((m_mask >> m_cursor) & 1) == 0) begin
          m_team[m_count] = m_cursor;
          m_mask |= (1 << m_cursor);
          m_count++;
          if (m_count == 3) m_state = 2;
        end else if (k == KB && m_count > 0) begin
          m_count--;
          m_mask &= ~(1 << m_team[m_count]);
          m_team[m_count] = 0;
        end
      end
      2: if (evt) begin
        if (k == KE) m_state = 3;
        else if (k == KB) begin
          m_mask &= ~(1 << m_team[2]);
          m_team[2] = 0;
          m_count = 2;
          m_state = 1;
        end
      end
      default: if (eb) begin
        m_state = 0;
        if (res && m_wins < 15) m_wins++;
      end
    endcase
  endtask

  // Drive one cycle of stimulus, queue the model's prediction, then compare after the edge.
  task automatic step(input bit [7:0] k, input bit st, input bit eb, input bit res);
    exp_t e;
    exp_t got;
    keycode    = k;
    start      = st;
    end_battle = eb;
    result     = res;
    model_step(k, st, eb, res);
    e.team   = {3'(m_team[2]), 3'(m_team[1]), 3'(m_team[0])};
    e.cursor = 3'(m_cursor);
    e.mask   = 6'(m_mask);
    e.count  = 2'(m_count);
    e.wins   = 4'(m_wins);
    e.isb    = (m_state == 3);
    sb_q.push_back(e);
    @(posedge Clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 0, 1);
    end else begin
      e = sb_q.pop_front();
      got = '{team: team, cursor: cursor, mask: picked_mask, count: picked_count,
              wins: wins, isb: is_battle};
      check_eq("team", int'(got.team), int'(e.team));
      check_eq("cursor", int'(got.cursor), int'(e.cursor));
      check_eq("mask", int'(got.mask), int'(e.mask));
      check_eq("count", int'(got.count), int'(e.count));
      check_eq("wins", int'(got.wins), int'(e.wins));
      check_eq("is_battle", int'(got.isb), int'(e.isb));
    end
  endtask

  task automatic key(input bit [7:0] k);
    step(k, 1'b0, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle_cycle();
    step(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_team"}, int'(team), 0);
    check_eq({tag, "_cursor"}, int'(cursor), 0);
    check_eq({tag, "_mask"}, int'(picked_mask), 0);
    check_eq({tag, "_count"}, int'(picked_count), 0);
    check_eq({tag, "_wins"}, int'(wins), 0);
    check_eq({tag, "_isb"}, int'(is_battle), 0);
  endtask

  // Start, pick ids 0,1,2, enter battle and end it with the given outcome.
  task automatic battle_round(input bit res);
    step(8'h00, 1'b1, 1'b0, 1'b0);
    key(KE); key(KD); key(KE); key(KD); key(KE);
    key(KE);
    step(8'h00, 1'b0, 1'b1, res);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; start = 1'b0; keycode = 8'h00; end_battle = 1'b0; result = 1'b0;
    model_reset();
    #2;
    check_all_zero("reset");
    @(posedge Clk);
    #1;
    Reset = 1'b0;

    // Ignored controls while idle/selecting; then the reference pick sequence.
    step(8'h00, 1'b0, 1'b1, 1'b1);
    step(8'h00, 1'b1, 1'b0, 1'b0);
    step(8'h00, 1'b1, 1'b1, 1'b1);
    key(KD); key(KE); key(KD); key(KE); key(KS); key(KE);
    check_eq("ref_team", int'(team), int'(9'b101_010_001));
    check_eq("ref_mask", int'(picked_mask), int'(6'b100110));
    check_eq("ref_isb", int'(is_battle), 0);

    // Confirm ignores cursor keys; backspace drops slot 2 and returns to select.
    key(KA);
    check_eq("confirm_cursor", int'(cursor), 5);
    key(KB);
    check_eq("confirm_bksp_mask", int'(picked_mask), int'(6'b000110));
    key(KE);
    key(KE);
    check_eq("battle_isb", int'(is_battle), 1);
    key(KB); key(KW); key(KE);
    step(8'h00, 1'b1, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b1, 1'b1);
    check_eq("win1", int'(wins), 1);
    check_eq("team_kept", int'(team), int'(9'b101_010_001));
    idle_cycle();

    // Held ENTER gives one pick; repeat pick ignored; backspace empties.
    step(8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(KE, 1'b0, 1'b0, 1'b0);
    idle_cycle();
    check_eq("held_count", int'(picked_count), 1);
    check_eq("held_mask", int'(picked_mask), 1);
    key(KE);
    key(KB);
    key(KB);

    // Cursor boundaries and back-to-back distinct keys.
    key(KW); key(KA);
    check_eq("corner0", int'(cursor), 0);
    key(KS); key(KD); key(KD); key(KS); key(KD);
    check_eq("corner5", int'(cursor), 5);
    step(KA, 1'b0, 1'b0, 1'b0);
    step(KD, 1'b0, 1'b0, 1'b0);
    idle_cycle();
    check_eq("a_then_d", int'(cursor), 5);
    key(KW); key(KA); key(KA);
    key(KE); key(KB); key(KE); key(KD); key(KE); key(KS); key(KE);
    key(KE);
    step(8'h00, 1'b0, 1'b1, 1'b0);
    check_eq("loss_no_win", int'(wins), 1);

    // Win saturation.
    for (int i = 0; i < 16; i++) battle_round(1'b1);
    check_eq("wins_sat", int'(wins), 15);

    // Reset in the middle of a battle.
    step(8'h00, 1'b1, 1'b0, 1'b0);
    key(KE); key(KD); key(KE); key(KD); key(KE); key(KE);
    #2;
    Reset = 1'b1;
    #1;
    check_all_zero("mid_reset");
    model_reset();
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    step(8'h00, 1'b1, 1'b0, 1'b0);
    key(KD);
    check_eq("post_reset_cursor", int'(cursor), 1);

    check_eq("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
